instr_fetch_mem: RTL

INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

---
 rtl/instr_fetch_mem.sv | 113 +++++++++++
 1 files changed

// File: rtl/instr_fetch_mem.sv
// Instruction fetch store: byte-loadable memory with a one-entry response register.
// Latency: one cycle from accepted request to resp_valid.
// Backpressure: req_ready drops while a response is held and resp_ready is low.
module instr_fetch_mem #(
  parameter int          MEM_BYTES  = 64,
  parameter int          ADDR_WIDTH = 64,
  parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_ready,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_instr,
  output logic [1:0]            resp_fault,
  output logic [ADDR_WIDTH-1:0] resp_addr,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [7:0]            load_data
);

  localparam int IDX_W = $clog2(MEM_BYTES);
  // Highest address at which a full word still fits inside the store.
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(MEM_BYTES - 4);
  localparam logic [ADDR_WIDTH-1:0] MEM_SIZE  = ADDR_WIDTH'(MEM_BYTES);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [31:0]             instr_q, instr_d;
  logic [1:0]              fault_q, fault_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              mem_q [MEM_BYTES];

  logic                    accept;
  logic                    misaligned;
  logic                    out_of_range;
  logic [IDX_W-1:0]        idx;
  logic [31:0]             rd_word;

  assign req_ready    = ((state_q == S_EMPTY) || resp_ready) && !reset;
  assign accept       = req_valid && req_ready;
  assign misaligned   = (req_addr[1:0] != 2'b00);
  // Full-width compare so that huge addresses never alias into the store.
  assign out_of_range = (req_addr > LAST_WORD);
  assign idx          = req_addr[IDX_W-1:0];

  assign resp_valid = (state_q == S_FULL);
  assign resp_instr = instr_q;
  assign resp_fault = fault_q;
  assign resp_addr  = addr_q;

  // Little-endian word read; only performed for aligned, in-range addresses.
  always_comb begin
    rd_word = '0;
    if (!misaligned && !out_of_range) begin
      rd_word = {mem_q[idx + IDX_W'(3)], mem_q[idx + IDX_W'(2)],
                 mem_q[idx + IDX_W'(1)], mem_q[idx]};
    end
  end

  // Next state of the response register; an accepted request always wins over flush/drain.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    fault_d = fault_q;
    addr_d  = addr_q;
    case (state_q)
      S_EMPTY: begin
        if (accept) state_d = S_FULL;
      end
      S_FULL: begin
        if (accept)                   state_d = S_FULL;
        else if (resp_ready || flush) state_d = S_EMPTY;
      end
      default: state_d = S_EMPTY;
    endcase
    if (accept) begin
      instr_d = (misaligned || out_of_range) ? NOP_INSTR : rd_word;
      fault_d = {out_of_range, misaligned};
      addr_d  = req_addr;
    end
  end

  // Response register with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_EMPTY;
      instr_q <= '0;
      fault_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
      addr_q  <= addr_d;
    end
  end

  // Program load port; unaffected by reset so images can be loaded during reset.
  always_ff @(posedge clk) begin
    if (load_en && (load_addr < MEM_SIZE)) begin
      mem_q[load_addr[IDX_W-1:0]] <= load_data;
    end
  end

endmodule
